// File: rtl/multdiv_arbiter_if.sv
// Bundle between the multdiv arbiter, its two requesters and the shared multdiv unit.
// Parameter: WIDTH - operand/result width, must match the multdiv unit.
// Modports:
//   slave  - arbiter side: takes reqX_*, md_result/md_exception/md_resultRDY;
//            drives reqX_ready, rspX_*, md_operandA/B, md_ctrl_MULT/DIV, busy.
//   master - environment side: the mirror image of slave.
interface multdiv_arbiter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req0_valid;
    logic             req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_ready;
    logic             rsp0_valid;
    logic [WIDTH-1:0] rsp0_data;
    logic             rsp0_exception;

    logic             req1_valid;
    logic             req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_ready;
    logic             rsp1_valid;
    logic [WIDTH-1:0] rsp1_data;
    logic             rsp1_exception;

    logic [WIDTH-1:0] md_operandA;
    logic [WIDTH-1:0] md_operandB;
    logic             md_ctrl_MULT;
    logic             md_ctrl_DIV;
    logic [WIDTH-1:0] md_result;
    logic             md_exception;
    logic             md_resultRDY;

    logic             busy;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  md_result, md_exception, md_resultRDY,
        output req0_ready, rsp0_valid, rsp0_data, rsp0_exception,
        output req1_ready, rsp1_valid, rsp1_data, rsp1_exception,
        output md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
        output busy
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output md_result, md_exception, md_resultRDY,
        input  req0_ready, rsp0_valid, rsp0_data, rsp0_exception,
        input  req1_ready, rsp1_valid, rsp1_data, rsp1_exception,
        input  md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
        input  busy
    );
endinterface

// File: rtl/multdiv_arbiter.sv
// Round-robin arbiter sharing one multdiv unit between two requesters.
// A granted request is latched, started with a one-cycle ctrl_MULT/ctrl_DIV
// pulse, and its result is returned as a one-cycle rspX_valid strobe to the
// requester that issued it. Only one operation is ever in flight.
// Ports:
//   clock   - system clock, rising edge
//   reset_n - asynchronous active-low reset
//   bus     - multdiv_arbiter_if.slave (request/response channels, multdiv side, busy)
// Parameters: WIDTH (operand width), TIMEOUT_CYCLES (WAIT limit).
// Optional feature: define MDARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles, returning data 0 with exception 1.
module multdiv_arbiter #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input logic              clock,
    input logic              reset_n,
    multdiv_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state;
    logic             last_grant;
    logic             id_q;

    logic             grant_any_c;
    logic             grant_id_c;
    logic             grant_op_c;
    logic             done_c;
    logic [WIDTH-1:0] done_data_c;
    logic             done_exc_c;

    // A zero limit would abort before the unit could ever answer.
    if (TIMEOUT_CYCLES == 0) begin : g_zero_timeout_unsupported
    end

`ifdef MDARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
`endif

    // Arbitration: contention goes to the requester not granted last.
    // ready is combinational so the handshake lands in the same cycle as valid;
    // it is forced low while reset is asserted.
    always_comb begin
        grant_any_c    = (state == S_IDLE) && (bus.req0_valid || bus.req1_valid);
        grant_id_c     = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
        grant_op_c     = grant_id_c ? bus.req1_op : bus.req0_op;
        bus.req0_ready = reset_n && grant_any_c && !grant_id_c;
        bus.req1_ready = reset_n && grant_any_c && grant_id_c;
    end

    // WAIT completion: a real result wins over a timeout in the same cycle.
    always_comb begin
        done_c      = bus.md_resultRDY;
        done_data_c = bus.md_result;
        done_exc_c  = bus.md_exception;
`ifdef MDARB_TIMEOUT_EN
        if (!bus.md_resultRDY && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1))) begin
            done_c      = 1'b1;
            done_data_c = '0;
            done_exc_c  = 1'b1;
        end
`endif
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state              <= S_IDLE;
            last_grant         <= 1'b1;
            id_q               <= 1'b0;
            bus.busy           <= 1'b0;
            bus.md_ctrl_MULT   <= 1'b0;
            bus.md_ctrl_DIV    <= 1'b0;
            bus.md_operandA    <= '0;
            bus.md_operandB    <= '0;
            bus.rsp0_valid     <= 1'b0;
            bus.rsp0_data      <= '0;
            bus.rsp0_exception <= 1'b0;
            bus.rsp1_valid     <= 1'b0;
            bus.rsp1_data      <= '0;
            bus.rsp1_exception <= 1'b0;
`ifdef MDARB_TIMEOUT_EN
            wait_cnt           <= '0;
`endif
        end else begin
            bus.md_ctrl_MULT <= 1'b0;
            bus.md_ctrl_DIV  <= 1'b0;
            bus.rsp0_valid   <= 1'b0;
            bus.rsp1_valid   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_any_c) begin
                        id_q             <= grant_id_c;
                        bus.md_operandA  <= grant_id_c ? bus.req1_a : bus.req0_a;
                        bus.md_operandB  <= grant_id_c ? bus.req1_b : bus.req0_b;
                        bus.md_ctrl_MULT <= !grant_op_c;
                        bus.md_ctrl_DIV  <= grant_op_c;
                        bus.busy         <= 1'b1;
                        state            <= S_START;
                    end
                end
                S_START: begin
                    // md_resultRDY is not looked at while the start pulse is out.
                    state <= S_WAIT;
`ifdef MDARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    if (done_c) begin
                        state <= S_RESP;
                        if (id_q) begin
                            bus.rsp1_valid     <= 1'b1;
                            bus.rsp1_data      <= done_data_c;
                            bus.rsp1_exception <= done_exc_c;
                        end else begin
                            bus.rsp0_valid     <= 1'b1;
                            bus.rsp0_data      <= done_data_c;
                            bus.rsp0_exception <= done_exc_c;
                        end
                    end
`ifdef MDARB_TIMEOUT_EN
                    else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                S_RESP: begin
                    last_grant <= id_q;
                    bus.busy   <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_arbiter.sv
// Self-checking bench for multdiv_arbiter: a behavioural multdiv stub with a
// per-operation latency, table-driven single requests, a held-contention
// round-robin sequence, reset during WAIT, and (with MDARB_TIMEOUT_EN) timeout.
module tb_multdiv_arbiter;

    localparam int unsigned W  = 32;
    localparam int unsigned TO = 8;

    typedef struct {
        bit          id;
        bit          op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;       // stub latency; 0 = stub never answers
        logic [31:0] exp_data;
        bit          exp_exc;
    } vec_t;

    logic clock = 1'b0;
    logic reset_n;

    multdiv_arbiter_if #(.WIDTH(W)) bus ();

    multdiv_arbiter #(
        .WIDTH          (W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Stub state (written only by the stub process).
    int          stub_lat = 0;
    int          stub_cnt = 0;
    logic [31:0] stub_res;
    bit          stub_exc;
    bit          prev_ctrl = 1'b0;
    int          both_cnt  = 0;
    int          long_cnt  = 0;
    int          rdy_fires = 0;

    vec_t src0[$], src1[$];   // ops waiting to be presented
    vec_t sb0[$],  sb1[$];    // scoreboard: expected responses per requester
    bit   shown0 = 1'b0, shown1 = 1'b0;

    // Behavioural multdiv: signed 32-bit ops, exception on overflow / divide by zero.
    always @(negedge clock) begin
        longint p;
        bit     ctrl;
        bus.md_resultRDY = 1'b0;
        ctrl = bus.md_ctrl_MULT || bus.md_ctrl_DIV;
        if (bus.md_ctrl_MULT && bus.md_ctrl_DIV) both_cnt++;
        if (ctrl && prev_ctrl) long_cnt++;
        prev_ctrl = ctrl;
        if (ctrl) begin
            if (bus.md_ctrl_MULT) begin
                p = longint'(signed'(bus.md_operandA)) * longint'(signed'(bus.md_operandB));
                stub_exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
                stub_res = stub_exc ? 32'd0 : p[31:0];
            end else if (bus.md_operandB == 32'd0) begin
                stub_exc = 1'b1;
                stub_res = 32'd0;
            end else begin
                stub_exc = 1'b0;
                stub_res = 32'(signed'(bus.md_operandA) / signed'(bus.md_operandB));
            end
            stub_cnt = stub_lat;
        end else if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0) begin
                bus.md_resultRDY = 1'b1;
                bus.md_result    = stub_res;
                bus.md_exception = stub_exc;
                rdy_fires++;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    // Present the front op of each source queue; push to the scoreboard on first presentation.
    task automatic drive();
        if (src0.size() > 0) begin
            bus.req0_valid = 1'b1;
            bus.req0_op    = src0[0].op;
            bus.req0_a     = src0[0].a;
            bus.req0_b     = src0[0].b;
            if (!shown0) begin sb0.push_back(src0[0]); shown0 = 1'b1; end
        end else begin
            bus.req0_valid = 1'b0;
        end
        if (src1.size() > 0) begin
            bus.req1_valid = 1'b1;
            bus.req1_op    = src1[0].op;
            bus.req1_a     = src1[0].a;
            bus.req1_b     = src1[0].b;
            if (!shown1) begin sb1.push_back(src1[0]); shown1 = 1'b1; end
        end else begin
            bus.req1_valid = 1'b0;
        end
    endtask

    // One full transaction from an idle arbiter; called at a negedge.
    task automatic step_grant(input bit exp_id);
        vec_t v, e;
        bit   any, g, got, rid;
        int   lat, bad, exp_lat;
        drive();
        #1;
        check("ready0", 64'(bus.req0_ready), 64'(exp_id == 1'b0));
        check("ready1", 64'(bus.req1_ready), 64'(exp_id == 1'b1));
        any = bus.req0_ready || bus.req1_ready;
        g   = any ? bus.req1_ready : exp_id;
        v   = g ? src1[0] : src0[0];
        stub_lat = v.lat;
        exp_lat  = (v.lat == 0) ? int'(TO) + 1 : v.lat + 1;
        @(posedge clock);
        if (any) begin
            if (g) begin void'(src1.pop_front()); shown1 = 1'b0; end
            else   begin void'(src0.pop_front()); shown0 = 1'b0; end
        end
        @(negedge clock);
        drive();
        check("ctrl_mult", 64'(bus.md_ctrl_MULT), 64'(!v.op));
        check("ctrl_div",  64'(bus.md_ctrl_DIV),  64'(v.op));
        check("ready_drop", 64'(bus.req0_ready || bus.req1_ready), 64'd0);
        check("busy_start", 64'(bus.busy), 64'd1);
        lat = 0; bad = 0; got = 1'b0;
        while (!got && lat < 200) begin
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                got = 1'b1;
            end else begin
                if (bus.md_operandA !== v.a || bus.md_operandB !== v.b) bad++;
                @(negedge clock);
                lat++;
            end
        end
        check("operands_stable", 64'(bad), 64'd0);
        check("resp_seen", 64'(got), 64'd1);
        if (got) begin
            check("latency", 64'(lat), 64'(exp_lat));
            rid = bus.rsp1_valid;
            check("rsp_route", 64'(rid), 64'(g));
            check("rsp_onehot", 64'(bus.rsp0_valid && bus.rsp1_valid), 64'd0);
            if (rid ? (sb1.size() > 0) : (sb0.size() > 0)) begin
                e = rid ? sb1.pop_front() : sb0.pop_front();
                check("rsp_data", 64'(rid ? bus.rsp1_data : bus.rsp0_data), 64'(e.exp_data));
                check("rsp_exc",  64'(rid ? bus.rsp1_exception : bus.rsp0_exception), 64'(e.exp_exc));
            end else begin
                check("scoreboard_empty", 64'd1, 64'd0);
            end
        end
        @(negedge clock);
        check("idle_after", 64'({bus.busy, bus.rsp0_valid, bus.rsp1_valid}), 64'd0);
    endtask

    vec_t tab[7];
    bit   order[4];

    initial begin
        int fires0, bad;
        tab[0] = '{1'b0, 1'b0, 32'd6,          32'd7,          2, 32'd42,         1'b0};
        tab[1] = '{1'b1, 1'b1, 32'd100,        32'd7,          3, 32'd14,         1'b0};
        tab[2] = '{1'b0, 1'b1, 32'd5,          32'd0,          1, 32'd0,          1'b1};
        tab[3] = '{1'b0, 1'b0, 32'd16777215,   32'hFF333334,   4, 32'd0,          1'b1};
        tab[4] = '{1'b1, 1'b0, 32'hFFFFFFFD,   32'd5,          1, 32'hFFFFFFF1,   1'b0};
        tab[5] = '{1'b0, 1'b1, 32'hFFFFFFEC,   32'd3,          5, 32'hFFFFFFFA,   1'b0};
        tab[6] = '{1'b1, 1'b0, 32'd1000,       32'd1000,       2, 32'h000F4240,   1'b0};
        order  = '{1'b0, 1'b1, 1'b0, 1'b1};

        reset_n        = 1'b0;
        bus.req0_valid = 1'b1;   // ready must stay low while in reset
        bus.req0_op    = 1'b0;
        bus.req0_a     = 32'd0;
        bus.req0_b     = 32'd0;
        bus.req1_valid = 1'b0;
        bus.req1_op    = 1'b0;
        bus.req1_a     = 32'd0;
        bus.req1_b     = 32'd0;
        repeat (3) @(negedge clock);
        check("rst_ready0", 64'(bus.req0_ready), 64'd0);
        check("rst_busy",   64'(bus.busy), 64'd0);
        check("rst_ctrl",   64'({bus.md_ctrl_MULT, bus.md_ctrl_DIV}), 64'd0);
        check("rst_rsp",    64'({bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_exception, bus.rsp1_exception}), 64'd0);
        check("rst_data",   64'({bus.rsp0_data, bus.rsp1_data}), 64'd0);
        check("rst_opnd",   64'({bus.md_operandA, bus.md_operandB}), 64'd0);
        bus.req0_valid = 1'b0;
        reset_n        = 1'b1;
        @(negedge clock);

        // Single requests from the table.
        for (int i = 0; i < 7; i++) begin
            if (tab[i].id) src1.push_back(tab[i]);
            else           src0.push_back(tab[i]);
            step_grant(tab[i].id);
        end
        check("rsp0_hold", 64'(bus.rsp0_data), 64'hFFFFFFFA);

        // Held contention straight after reset: grants alternate starting with requester 0.
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        src0.push_back('{1'b0, 1'b0, 32'd3,  32'd4, 2, 32'd12, 1'b0});
        src0.push_back('{1'b0, 1'b1, 32'd81, 32'd9, 3, 32'd9,  1'b0});
        src1.push_back('{1'b1, 1'b0, 32'd7,  32'd8, 1, 32'd56, 1'b0});
        src1.push_back('{1'b1, 1'b1, 32'd64, 32'd4, 2, 32'd16, 1'b0});
        for (int i = 0; i < 4; i++) step_grant(order[i]);

        // Reset while in WAIT: everything clears, the late RDY is ignored.
        stub_lat       = 10;
        bus.req0_valid = 1'b1;
        bus.req0_op    = 1'b0;
        bus.req0_a     = 32'd9;
        bus.req0_b     = 32'd9;
        @(posedge clock);
        @(negedge clock);
        bus.req0_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("wait_busy", 64'(bus.busy), 64'd1);
        fires0         = rdy_fires;
        reset_n        = 1'b0;
        bus.req0_valid = 1'b1;
        #1;
        check("abort_busy",  64'(bus.busy), 64'd0);
        check("abort_ready", 64'(bus.req0_ready), 64'd0);
        check("abort_opnd",  64'({bus.md_operandA, bus.md_operandB}), 64'd0);
        check("abort_data",  64'({bus.rsp0_data, bus.rsp1_data}), 64'd0);
        @(negedge clock);
        bus.req0_valid = 1'b0;
        reset_n        = 1'b1;
        bad = 0;
        repeat (12) begin
            @(negedge clock);
            if (bus.rsp0_valid || bus.rsp1_valid || bus.busy) bad++;
        end
        check("late_rdy_ignored", 64'(bad), 64'd0);
        check("late_rdy_fired",   64'(rdy_fires - fires0), 64'd1);
        src1.push_back('{1'b1, 1'b1, 32'd50, 32'd5, 2, 32'd10, 1'b0});
        step_grant(1'b1);

`ifdef MDARB_TIMEOUT_EN
        // Stub stays silent: the arbiter answers data 0 / exception 1 after TO WAIT cycles.
        src0.push_back('{1'b0, 1'b0, 32'd2, 32'd3, 0, 32'd0, 1'b1});
        step_grant(1'b0);
`endif

        check("ctrl_never_both",   64'(both_cnt), 64'd0);
        check("ctrl_single_cycle", 64'(long_cnt), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_checks);
        $fatal(1);
    end

endmodule
